// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - TL-UL opcode constants shared by all TL-UL endpoints
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    function automatic logic is_put_op(input logic [2:0] opcode);
        return (opcode == PUT_FULL) || (opcode == PUT_PARTIAL);
    endfunction

endpackage

// File: rtl/tl_ram_array.sv
// rtl/tl_ram_array.sv - DEPTH x 32 word store, byte write enables, comb read
module tl_ram_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/tl_ul_ram_responder.sv
// rtl/tl_ul_ram_responder.sv - TL-UL responder serving Get/Put from an internal RAM
module tl_ul_ram_responder
    import tl_ul_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                SRC_W  = 4,
    parameter int                DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [1:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_mask,
    input  logic [DATA_W-1:0] a_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic              d_denied,
    output logic [DATA_W-1:0] d_data
);

    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DEPTH) << 2;

    logic              a_fire;
    logic              d_fire;
    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic              aligned;
    logic              is_get;
    logic              is_put;
    logic              legal;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;
    logic              unused_bits;

    assign a_ready = !d_valid || d_ready;
    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;

    always_comb begin
        offset   = a_address - BASE;
        in_range = (a_address >= BASE) && ({1'b0, offset} < SPAN);
        case (a_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = !a_address[0];
            2'd2:    aligned = (a_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        is_get = (a_opcode == GET);
        is_put = is_put_op(a_opcode);
        legal  = (is_get || is_put) && (a_size != 2'd3) && in_range && aligned;
    end

    assign idx = offset[IDX_W+1:2];

    // A request accepted while reset is high must not reach the RAM.
    assign ram_we = (a_fire && !reset && is_put && legal) ? a_mask : 4'b0000;

    assign unused_bits = ^{a_param, offset[1:0], offset[ADDR_W-1:IDX_W+2]};

    tl_ram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (idx),
        .wdata (a_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid  <= 1'b0;
            d_opcode <= ACCESS_ACK;
            d_size   <= '0;
            d_source <= '0;
            d_denied <= 1'b0;
            d_data   <= '0;
        end else if (a_fire) begin
            d_valid  <= 1'b1;
            d_opcode <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            d_size   <= a_size;
            d_source <= a_source;
            d_denied <= !legal;
            d_data   <= (is_get && legal) ? ram_rdata : '0;
        end else if (d_fire) begin
            d_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// tb/tb_tl_ul_ram_responder.sv - scoreboard bench for tl_ul_ram_responder
module tb_tl_ul_ram_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [41:0] sb[$];
    int          beat_cycs[$];
    logic [31:0] model_mem [DEPTH];

    tl_ul_ram_responder #(
        .ADDR_W (32),
        .DATA_W (32),
        .SRC_W  (4),
        .DEPTH  (DEPTH),
        .BASE   (BASE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_req(input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                              input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        longint      a;
        bit          in_rng;
        bit          al;
        bit          legal;
        int          w;
        logic [31:0] rd;
        a      = longint'(addr);
        in_rng = (a >= longint'(BASE)) && (a < longint'(BASE) + DEPTH * 4);
        al     = (addr % (32'd1 << size)) == 0;
        legal  = (op inside {3'd0, 3'd1, 3'd4}) && (size <= 2'd2) && in_rng && al;
        rd     = '0;
        if (legal) begin
            w = int'((a - longint'(BASE)) / 4);
            if (op == 3'd4) rd = model_mem[w];
            else begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
            end
        end
        sb.push_back({(op == 3'd4) ? 3'd1 : 3'd0, size, src, !legal, rd});
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        int waited = 0;
        @(posedge clock); #1;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        @(negedge clock);
        while (!a_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (a_ready) expect_req(op, size, src, addr, mask, data);
        else check_eq("a_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        @(posedge clock); #1;
        a_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset && d_valid && d_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_beat", 64'd1, 64'd0);
            end else begin
                check_eq("d_beat", {d_opcode, d_size, d_source, d_denied, d_data}, sb.pop_front());
                beat_cycs.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int c0;
        reset = 1'b1; a_valid = 1'b0; d_ready = 1'b1;
        a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("reset_d_valid", d_valid, 1'b0);
        check_eq("reset_a_ready", a_ready, 1'b1);
        check_eq("reset_d_fields", {d_opcode, d_size, d_source, d_denied, d_data}, 42'd0);

        // full put, then read-after-write on the very next cycle
        send(3'd0, 2'd2, 4'd1, BASE + 32'h0, 4'hF, 32'h11111111);
        n0 = beat_cycs.size();
        send(3'd0, 2'd2, 4'd3, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
        c0 = cyc;
        send(3'd4, 2'd2, 4'd5, BASE + 32'h10, 4'h0, 32'h0);
        idle();
        repeat (3) @(posedge clock);
        check_eq("put_latency", beat_cycs[n0 + 1] - c0, 1);

        send(3'd1, 2'd1, 4'd2, BASE + 32'h12, 4'hC, 32'h12340000);
        send(3'd4, 2'd2, 4'd2, BASE + 32'h10, 4'h0, 32'h0);
        send(3'd4, 2'd0, 4'd6, BASE + 32'h13, 4'h0, 32'h0);
        send(3'd0, 2'd2, 4'd9, BASE + DEPTH * 4 - 4, 4'hF, 32'hCAFEF00D);
        send(3'd4, 2'd2, 4'd9, BASE + DEPTH * 4 - 4, 4'h0, 32'h0);
        idle();
        repeat (3) @(posedge clock);

        // backpressure with a second request held on A
        #1 d_ready = 1'b0;
        send(3'd4, 2'd2, 4'd7, BASE + 32'h0, 4'h0, 32'h0);
        @(posedge clock); #1;
        a_source = 4'd8; a_address = BASE + 32'h10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("stall_d_valid", d_valid, 1'b1);
            check_eq("stall_a_ready", a_ready, 1'b0);
            check_eq("stall_hold", {d_opcode, d_size, d_source, d_denied, d_data}, sb[0]);
        end
        @(posedge clock); #1 d_ready = 1'b1;
        @(negedge clock);
        check_eq("release_a_ready", a_ready, 1'b1);
        if (a_ready) expect_req(3'd4, 2'd2, 4'd8, BASE + 32'h10, 4'h0, 32'h0);
        idle();
        repeat (3) @(posedge clock);

        // full throughput
        for (int i = 0; i < 8; i++)
            send(3'd0, 2'd2, 4'(i), BASE + 32'h40 + 32'(i * 4), 4'hF, $urandom);
        idle();
        repeat (3) @(posedge clock);
        n0 = beat_cycs.size();
        for (int i = 0; i < 8; i++)
            send(3'd4, 2'd2, 4'(i), BASE + 32'h40 + 32'(i * 4), 4'h0, 32'h0);
        idle();
        repeat (3) @(posedge clock);
        check_eq("burst_count", beat_cycs.size() - n0, 8);
        if (beat_cycs.size() - n0 == 8)
            check_eq("burst_span", beat_cycs[n0 + 7] - beat_cycs[n0], 7);

        // illegal requests
        send(3'd4, 2'd2, 4'd1, BASE + DEPTH * 4, 4'h0, 32'h0);
        send(3'd0, 2'd2, 4'd2, BASE + 32'h2, 4'hF, 32'hFFFFFFFF);
        send(3'd4, 2'd2, 4'd3, BASE + 32'h0, 4'h0, 32'h0);
        send(3'd6, 2'd2, 4'd4, BASE + 32'h20, 4'hF, 32'h55);
        send(3'd0, 2'd3, 4'd5, BASE + 32'h20, 4'hF, 32'h66);
        idle();
        repeat (3) @(posedge clock);

        // reset with a pending beat, then an A fire during reset
        #1 d_ready = 1'b0;
        send(3'd4, 2'd2, 4'd7, BASE + 32'h10, 4'h0, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        a_valid = 1'b1; a_opcode = 3'd0; a_size = 2'd2; a_source = 4'd1;
        a_address = BASE + 32'h10; a_mask = 4'hF; a_data = 32'hBAD0BAD0;
        @(negedge clock);
        @(negedge clock);
        check_eq("reset_drops_d", d_valid, 1'b0);
        check_eq("reset_a_ready_high", a_ready, 1'b1);
        @(posedge clock); #1;
        reset = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
        repeat (3) @(posedge clock);
        send(3'd4, 2'd2, 4'd2, BASE + 32'h10, 4'h0, 32'h0);
        idle();
        repeat (3) @(posedge clock);
        check_eq("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_ul_ram_responder.md
# tl_ul_ram_responder

TileLink-UL responder (slave) terminating the A/D channel bundle that the bus-side wrappers forward unchanged. Accepts Get, PutFullData and PutPartialData on channel A, services them from an internal word-addressed RAM, and returns AccessAck / AccessAckData on channel D. Sits at the far end of the core's peripheral/TCM port as the memory-side counterpart to the initiator-side pass-through bundles.

## Interface
- ADDR_W, 32, A-channel address width
- DATA_W, 32, data width; fixed at 32, giving 4 byte lanes
- SRC_W, 4, source ID width
- DEPTH, 1024, RAM depth in words; must be a power of two
- BASE, 32'h0, byte base address; must be aligned to DEPTH*4

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- a_valid  in  1  A beat valid
- a_ready  out  1  A beat accepted when a_valid && a_ready
- a_opcode  in  3  0 = PutFullData, 1 = PutPartialData, 4 = Get
- a_param  in  3  ignored; must be 0
- a_size  in  2  log2 of bytes (0..2)
- a_source  in  SRC_W  request ID, echoed on D
- a_address  in  ADDR_W  byte address
- a_mask  in  4  byte-lane enables
- a_data  in  32  write data
- d_valid  out  1  D beat valid
- d_ready  in  1  D beat consumed when d_valid && d_ready
- d_opcode  out  3  0 = AccessAck, 1 = AccessAckData
- d_size  out  2  echo of a_size
- d_source  out  SRC_W  echo of a_source
- d_denied  out  1  request rejected
- d_data  out  32  read data; 0 for AccessAck and for any denied response

## Operation
- Single response register: d_valid, d_opcode, d_size, d_source, d_denied, d_data.
- a_ready = !d_valid || d_ready, which gives full throughput of one request per cycle.
- On A fire, the request is decoded as follows:
  - Index: word index = (a_address - BASE) >> 2.
  - In range: the address is in range iff BASE <= a_address < BASE + DEPTH*4.
  - Aligned: the address is aligned iff its low a_size bits are 0.
  - Legal: the request is legal iff the opcode is in {0, 1, 4}, a_size <= 2, the address is in range and aligned.
- Put, legal:
  - Write a_data into the byte lanes selected by a_mask.
  - Respond AccessAck with d_denied = 0.
  - PutFullData uses a_mask as given; no extra mask check.
- Get, legal:
  - Respond AccessAckData with d_data = the full word at the index.
  - Requester extracts its bytes.
- Illegal request:
  - No RAM write.
  - d_denied = 1, d_data = 0.
  - d_opcode = AccessAckData for opcode 4; AccessAck otherwise, including unsupported opcodes.
- Read-after-write: a Get accepted the cycle after a Put to the same word returns the new data. The write commits at the Put's fire edge, before the Get reads.
- A fire and D fire in the same cycle: the response register is reloaded with the new response; d_valid stays 1.
- D fire without A fire: d_valid clears.
- While d_valid && !d_ready, all D outputs hold stable.

## Timing
- Latency: A fire at edge N gives d_valid = 1 after edge N (visible in cycle N+1).
- Reset values: d_valid = 0, d_opcode = 0, d_size = 0, d_source = 0, d_denied = 0, d_data = 0.
- a_ready = 1 in the cycle after reset.
- RAM contents are not reset.
- Reset mid-operation: any pending response is dropped. No D beat is issued for it, and its write (if already committed) stays in RAM.
- Asserting reset in the same cycle as an A fire: the write does not commit and no response is produced.
- No combinational path from a_* to d_*. The only combinational path is d_ready -> a_ready.

## Structure
- Shared package `tl_ul_pkg`:
  - opcode constants PUT_FULL = 3'd0, PUT_PARTIAL = 3'd1, GET = 3'd4, ACCESS_ACK = 3'd0, ACCESS_ACK_DATA = 3'd1
  - shared by all TL-UL endpoints
- Sub-module `tl_ram_array`: DEPTH x 32 storage with a 4-bit byte write enable and a synchronous-write/combinational-read port. Kept separate so it can be swapped for a macro.
- Top level contains the decode/legality logic and the response register.

## Test plan
- Reset, then idle:
  - d_valid = 0 and a_ready = 1 in the first post-reset cycle.
- PutFullData then Get:
  - PutFullData to BASE+0x10, data 0xDEADBEEF, mask 0xF, source 3 -> AccessAck, source 3, denied 0, one cycle later.
  - Next-cycle Get of the same word -> AccessAckData, data 0xDEADBEEF.
- PutPartialData then Get:
  - PutPartialData to BASE+0x12, size 1, mask 0xC, data 0x12340000 -> AccessAck.
  - Get of BASE+0x10 -> 0x1234BEEF.
- Backpressure:
  - Hold d_ready = 0 for 5 cycles with a Get pending -> D outputs stable and a_ready = 0 throughout.
  - Release d_ready -> a response on every cycle at full throughput for 8 back-to-back Gets.
- Error cases:
  - Get at BASE + DEPTH*4 -> AccessAckData, denied 1, data 0.
  - Put at BASE+0x2, size 2 -> AccessAck, denied 1, RAM unchanged.
  - Opcode 6 -> AccessAck, denied 1.
- Reset mid-operation:
  - Assert reset while d_valid = 1 and d_ready = 0 -> d_valid = 0 the next cycle, and no stale beat appears after reset.
